// File: rtl/motor_start_sequencer.sv
// -----------------------------------------------------------------------------
// motor_start_sequencer
//
// Start/stop sequencer for the two-motor drive stage. A start request plus a
// mode selection is turned into timed enables for MOTOR1 and MOTOR2:
//   - dual mode (MODO=1): MOTOR1 starts first, MOTOR2 joins RETARDO cycles later
//     and both stay on until a stop or a fault.
//   - alternate mode (MODO=0): the motors take turns. Each phase lasts T_ALT
//     cycles, and its first cycle is a dead band with both motors off.
// A fault always wins. From the fault state the sequencer returns to idle only
// after the fault has cleared and the start request has been released.
//
// Ports
//   CLK       in   1  system clock, rising edge
//   REINICIO  in   1  asynchronous reset, active low
//   ARRANQUE  in   1  start request (level)
//   PARO      in   1  stop request (level)
//   MODO      in   1  1 = dual staggered, 0 = alternating; latched at start
//   FALLA     in   1  external fault (level)
//   MOTOR1    out  1  enable for motor 1
//   MOTOR2    out  1  enable for motor 2
//   ESTADO    out  3  current state code
//   ALARMA    out  1  high while in the fault state
// -----------------------------------------------------------------------------
module motor_start_sequencer #(
  parameter int CNT_W   = 8,
  parameter int RETARDO = 4,
  parameter int T_ALT   = 6
) (
  input  logic       CLK,
  input  logic       REINICIO,
  input  logic       ARRANQUE,
  input  logic       PARO,
  input  logic       MODO,
  input  logic       FALLA,
  output logic       MOTOR1,
  output logic       MOTOR2,
  output logic [2:0] ESTADO,
  output logic       ALARMA
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START_M1 = 3'd1,
    DUAL     = 3'd2,
    ALT_M1   = 3'd3,
    ALT_M2   = 3'd4,
    FAULT    = 3'd5
  } state_t;

  // Terminal counts. The counter is cleared on every state change, so it
  // never needs to count past these values.
  localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(RETARDO - 1);
  localparam logic [CNT_W-1:0] ALT_LAST = CNT_W'(T_ALT - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             modo_q;
  logic             modo_next;

  // State register. Reset takes effect immediately, without waiting for a
  // clock edge, so the motors drop at once when REINICIO goes low.
  always_ff @(posedge CLK or negedge REINICIO) begin
    if (!REINICIO) begin
      state  <= IDLE;
      cnt    <= '0;
      modo_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      modo_q <= modo_next;
    end
  end

  // Next-state logic. The fault input is checked first, then the stop
  // request, and only then the start request and the phase timers.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    modo_next  = modo_q;

    if (FALLA) begin
      state_next = FAULT;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_next = '0;
          // If start and stop arrive together, stop wins and the sequencer
          // stays idle.
          if (ARRANQUE && !PARO) begin
            modo_next  = MODO;
            state_next = MODO ? START_M1 : ALT_M1;
          end
        end

        START_M1: begin
          if (PARO) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt == RET_LAST) begin
            state_next = DUAL;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end

        DUAL: begin
          cnt_next = '0;
          if (PARO) begin
            state_next = IDLE;
          end
        end

        ALT_M1: begin
          if (PARO) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt == ALT_LAST) begin
            state_next = ALT_M2;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end

        ALT_M2: begin
          if (PARO) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt == ALT_LAST) begin
            state_next = ALT_M1;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end

        FAULT: begin
          cnt_next = '0;
          // Leaving the fault state also requires the start request to be
          // released. A start request that is held through a fault must
          // never restart the motors on its own.
          if (!ARRANQUE) begin
            state_next = IDLE;
          end
        end

        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Output decode. The outputs depend only on registered state, so there is
  // no path from the operator inputs to the motor drivers. Count zero of each
  // alternate phase is the dead cycle. DUAL can only be entered with modo_q
  // set, so gating MOTOR2 with modo_q changes nothing in normal operation; it
  // keeps a corrupted state from turning on both motors.
  always_comb begin
    MOTOR1 = (state == START_M1) || (state == DUAL) ||
             ((state == ALT_M1) && (cnt != '0));
    MOTOR2 = ((state == DUAL) && modo_q) ||
             ((state == ALT_M2) && (cnt != '0));
    ESTADO = state;
    ALARMA = (state == FAULT);
  end

endmodule
